// File: rtl/soc_nios2_trace_pkg.sv
// Shared widths, frame layout and sequencer states for the Nios II OCI
// direct-branch trace capture path.
package soc_nios2_trace_pkg;

   localparam int CODE_W      = 2;
   localparam int MAX_ENTRIES = 15;
   localparam int CNT_W       = 4;
   localparam int BUF_W       = MAX_ENTRIES * CODE_W;
   localparam int FRAME_W     = CNT_W + BUF_W;

   typedef struct packed {
      logic [CNT_W-1:0] count;
      logic [BUF_W-1:0] buffer;
   } trace_frame_t;

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2
   } trace_state_e;

endpackage

// File: rtl/soc_nios2_trace_frame_reg.sv
// One-deep valid/ready output register that holds a committed trace frame
// until the trace FIFO accepts it.
module soc_nios2_trace_frame_reg #(
   parameter int DATA_W = soc_nios2_trace_pkg::FRAME_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_free
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;

   // A load in the same cycle as a retire wins, so back-to-back frames keep valid high.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end
   end

   // NOTE: the data register is reset as well because frame_data is a visible
   // output that must read zero after reset, not just a don't-care behind valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_free  = !valid_q || out_ready;

endmodule

// File: rtl/soc_nios2_dct_trace_ctrl.sv
// Direct-branch trace sequencer: packs 2-bit branch codes into dct_buffer and
// commits full, flushed or drained buffers as frames to the output register.
module soc_nios2_dct_trace_ctrl
   import soc_nios2_trace_pkg::*;
#(
   parameter int MAX_ENTRIES = soc_nios2_trace_pkg::MAX_ENTRIES,
   parameter int CODE_W      = soc_nios2_trace_pkg::CODE_W,
   parameter int CNT_W       = soc_nios2_trace_pkg::CNT_W,
   parameter int DROP_W      = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            trace_en,
   input  logic                            dct_valid,
   input  logic [CODE_W-1:0]               dct_code,
   input  logic                            flush_req,
   input  logic                            frame_ready,
   output logic                            frame_valid,
   output logic [CNT_W+MAX_ENTRIES*CODE_W-1:0] frame_data,
   output logic [MAX_ENTRIES*CODE_W-1:0]   dct_buffer,
   output logic [CNT_W-1:0]                dct_count,
   output logic                            overflow,
   input  logic                            overflow_clr,
   output logic [DROP_W-1:0]               drop_count
);

   localparam int               L_BUF_W   = MAX_ENTRIES * CODE_W;
   localparam int               L_FRAME_W = CNT_W + L_BUF_W;
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(MAX_ENTRIES - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(MAX_ENTRIES);

   trace_state_e         state_q, state_d;
   logic [L_BUF_W-1:0]   buf_q, buf_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 flush_pend_q, flush_pend_d;
   logic                 overflow_q, overflow_d;
   logic [DROP_W-1:0]    drop_q, drop_d;

   logic                 out_free;
   logic                 commit;
   logic [L_FRAME_W-1:0] commit_data;
   logic                 drop;
   logic                 flush_active;
   logic [L_BUF_W-1:0]   buf_app;
   logic [CNT_W-1:0]     cnt_app;

   // NOTE: combinational next-state logic uses blocking assignments with every
   // output defaulted first, so no path can leave a latch behind.
   always_comb begin
      state_d      = state_q;
      buf_d        = buf_q;
      cnt_d        = cnt_q;
      flush_pend_d = flush_pend_q;
      commit       = 1'b0;
      commit_data  = '0;
      drop         = 1'b0;
      buf_app      = {buf_q[L_BUF_W-CODE_W-1:0], dct_code};
      cnt_app      = cnt_q + CNT_W'(1);
      flush_active = flush_req || flush_pend_q;

      unique case (state_q)
         ST_OFF: begin
            flush_pend_d = 1'b0;
            if (trace_en) begin
               state_d = ST_COLLECT;
            end
         end

         ST_COLLECT: begin
            if (!trace_en) begin
               state_d = ST_DRAIN;
            end
            if (dct_valid && (cnt_q == LAST_IDX)) begin
               // Final code of a frame: a same-cycle flush folds into the full commit.
               if (out_free) begin
                  commit       = 1'b1;
                  commit_data  = {FULL_CNT, buf_app};
                  buf_d        = '0;
                  cnt_d        = '0;
                  flush_pend_d = 1'b0;
               end else begin
                  drop         = 1'b1;
                  flush_pend_d = flush_active;
               end
            end else begin
               if (dct_valid) begin
                  buf_d = buf_app;
                  cnt_d = cnt_app;
               end
               if (flush_active && (cnt_d != '0)) begin
                  if (out_free) begin
                     commit       = 1'b1;
                     commit_data  = {cnt_d, buf_d};
                     buf_d        = '0;
                     cnt_d        = '0;
                     flush_pend_d = 1'b0;
                  end else begin
                     flush_pend_d = 1'b1;
                  end
               end else begin
                  flush_pend_d = 1'b0;
               end
            end
         end

         ST_DRAIN: begin
            // The drain commit carries any pending flush with it.
            flush_pend_d = 1'b0;
            if (cnt_q == '0) begin
               state_d = ST_OFF;
            end else if (out_free) begin
               commit      = 1'b1;
               commit_data = {cnt_q, buf_q};
               buf_d       = '0;
               cnt_d       = '0;
               state_d     = ST_OFF;
            end
         end

         default: begin
            state_d      = ST_OFF;
            flush_pend_d = 1'b0;
         end
      endcase

      overflow_d = overflow_q;
      drop_d     = drop_q;
      if (overflow_clr) begin
         overflow_d = 1'b0;
         drop_d     = '0;
      end else if (drop) begin
         overflow_d = 1'b1;
         if (drop_q != '1) begin
            drop_d = drop_q + DROP_W'(1);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_OFF;
         buf_q        <= '0;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
         overflow_q   <= 1'b0;
         drop_q       <= '0;
      end else begin
         state_q      <= state_d;
         buf_q        <= buf_d;
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
         overflow_q   <= overflow_d;
         drop_q       <= drop_d;
      end
   end

   soc_nios2_trace_frame_reg #(
      .DATA_W (L_FRAME_W)
   ) u_frame_reg (
      .clk       (clk),
      .reset     (reset),
      .load      (commit),
      .load_data (commit_data),
      .out_ready (frame_ready),
      .out_valid (frame_valid),
      .out_data  (frame_data),
      .out_free  (out_free)
   );

   assign dct_buffer = buf_q;
   assign dct_count  = cnt_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_soc_nios2_dct_trace_ctrl.sv
// Directed bench for the direct-branch trace sequencer with hand-computed frames.
module tb_soc_nios2_dct_trace_ctrl;
   import soc_nios2_trace_pkg::*;

   logic               clk;
   logic               reset;
   logic               trace_en;
   logic               dct_valid;
   logic [CODE_W-1:0]  dct_code;
   logic               flush_req;
   logic               frame_ready;
   logic               frame_valid;
   logic [FRAME_W-1:0] frame_data;
   logic [BUF_W-1:0]   dct_buffer;
   logic [CNT_W-1:0]   dct_count;
   logic               overflow;
   logic               overflow_clr;
   logic [7:0]         drop_count;

   int n_checks = 0;
   int n_errors = 0;

   trace_frame_t exp_frame;

   soc_nios2_dct_trace_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .trace_en     (trace_en),
      .dct_valid    (dct_valid),
      .dct_code     (dct_code),
      .flush_req    (flush_req),
      .frame_ready  (frame_ready),
      .frame_valid  (frame_valid),
      .frame_data   (frame_data),
      .dct_buffer   (dct_buffer),
      .dct_count    (dct_count),
      .overflow     (overflow),
      .overflow_clr (overflow_clr),
      .drop_count   (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge and sample 1ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [1:0] code, input int n);
      dct_valid = 1'b1;
      dct_code  = code;
      repeat (n) step();
      dct_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; trace_en = 1'b0; dct_valid = 1'b0; dct_code = '0;
      flush_req = 1'b0; frame_ready = 1'b0; overflow_clr = 1'b0;
      step(); step();
      reset = 1'b0;
      check("rst_valid", frame_valid, 0);
      check("rst_data", frame_data, 0);
      check("rst_count", dct_count, 0);
      check("rst_buffer", dct_buffer, 0);
      check("rst_overflow", overflow, 0);
      check("rst_drop", drop_count, 0);

      // Full frame of 15 x 2'b01, latency one edge.
      trace_en = 1'b1; frame_ready = 1'b1;
      step();
      feed(2'b01, 14);
      check("t1_count14", dct_count, 14);
      check("t1_buf14", dct_buffer, 30'h0555_5555);
      check("t1_no_frame_yet", frame_valid, 0);
      feed(2'b01, 1);
      exp_frame.count  = 4'd15;
      exp_frame.buffer = 30'h1555_5555;
      check("t1_valid", frame_valid, 1);
      check("t1_data", frame_data, exp_frame);
      check("t1_count0", dct_count, 0);
      check("t1_buf0", dct_buffer, 0);
      step();
      check("t1_retired", frame_valid, 0);

      // Partial flush after 5 x 2'b11.
      feed(2'b11, 5);
      check("t2_count5", dct_count, 5);
      check("t2_buf", dct_buffer, 30'h3FF);
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      check("t2_valid", frame_valid, 1);
      check("t2_data", frame_data, {4'd5, 30'h3FF});
      check("t2_count0", dct_count, 0);
      step();
      check("t2_retired", frame_valid, 0);

      // Back-pressure: first frame held, 15th code of second frame dropped.
      frame_ready = 1'b0;
      feed(2'b10, 15);
      check("t3_valid_a", frame_valid, 1);
      check("t3_data_a", frame_data, {4'd15, 30'h2AAA_AAAA});
      feed(2'b11, 14);
      check("t3_stable_a", frame_data, {4'd15, 30'h2AAA_AAAA});
      check("t3_count14", dct_count, 14);
      check("t3_no_ovf_yet", overflow, 0);
      feed(2'b11, 1);
      check("t3_count_held", dct_count, 14);
      check("t3_buf_held", dct_buffer, 30'h0FFF_FFFF);
      check("t3_overflow", overflow, 1);
      check("t3_drop1", drop_count, 1);
      check("t3_still_a", frame_data, {4'd15, 30'h2AAA_AAAA});
      frame_ready = 1'b1;
      step();
      check("t3_retire_a", frame_valid, 0);
      feed(2'b01, 1);
      check("t3_valid_b", frame_valid, 1);
      check("t3_data_b", frame_data, {4'd15, 30'h3FFF_FFFD});
      check("t3_count0", dct_count, 0);
      step();
      overflow_clr = 1'b1;
      step();
      overflow_clr = 1'b0;
      check("t3_ovf_clr", overflow, 0);
      check("t3_drop_clr", drop_count, 0);

      // Drain a 3-code partial buffer on disable; OFF ignores codes.
      feed(2'b10, 1);
      feed(2'b01, 1);
      feed(2'b11, 1);
      check("t4_buf", dct_buffer, 30'h27);
      trace_en = 1'b0;
      step();
      check("t4_drain_wait", frame_valid, 0);
      step();
      check("t4_valid", frame_valid, 1);
      check("t4_data", frame_data, {4'd3, 30'h27});
      check("t4_count0", dct_count, 0);
      feed(2'b11, 3);
      check("t4_off_valid", frame_valid, 0);
      check("t4_off_count", dct_count, 0);
      check("t4_off_drop", drop_count, 0);
      check("t4_off_ovf", overflow, 0);

      // Flush together with the 15th code: single full frame.
      trace_en = 1'b1;
      step();
      feed(2'b01, 14);
      dct_valid = 1'b1; dct_code = 2'b10; flush_req = 1'b1;
      step();
      dct_valid = 1'b0; flush_req = 1'b0;
      check("t5_valid", frame_valid, 1);
      check("t5_data", frame_data, {4'd15, 30'h1555_5556});
      check("t5_count0", dct_count, 0);
      step();
      check("t5_no_partial1", frame_valid, 0);
      step();
      check("t5_no_partial2", frame_valid, 0);

      // Pending flush served on the retire cycle.
      frame_ready = 1'b0;
      feed(2'b01, 15);
      feed(2'b10, 2);
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      check("t6_pend_count", dct_count, 2);
      check("t6_pend_hold", frame_data, {4'd15, 30'h1555_5555});
      frame_ready = 1'b1;
      step();
      check("t6_pend_valid", frame_valid, 1);
      check("t6_pend_data", frame_data, {4'd2, 30'hA});
      check("t6_pend_count0", dct_count, 0);
      step();
      check("t6_pend_retired", frame_valid, 0);

      // Reset mid-operation with count 9 and a held frame.
      frame_ready = 1'b0;
      feed(2'b01, 4);
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      check("t7_held_data", frame_data, {4'd4, 30'h55});
      feed(2'b11, 9);
      check("t7_count9", dct_count, 9);
      check("t7_held_valid", frame_valid, 1);
      reset = 1'b1; trace_en = 1'b0;
      step();
      reset = 1'b0;
      check("t7_rst_valid", frame_valid, 0);
      check("t7_rst_data", frame_data, 0);
      check("t7_rst_count", dct_count, 0);
      check("t7_rst_buf", dct_buffer, 0);
      frame_ready = 1'b1;
      feed(2'b01, 2);
      check("t7_off_valid", frame_valid, 0);
      check("t7_off_count", dct_count, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
